// File: rtl/uart_cmd_pkg.sv
// Shared types, status codes and defaults for the UART command sequencer.
package uart_cmd_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 6;

  localparam logic [BYTE_W-1:0] HEADER_DEFAULT  = 8'hA5;
  localparam int unsigned       TIMEOUT_DEFAULT = 640;
  localparam int unsigned       TO_W_DEFAULT    = 10;

  localparam logic [BYTE_W-1:0] ST_OK      = 8'h00;
  localparam logic [BYTE_W-1:0] ST_BADCHK  = 8'hE1;
  localparam logic [BYTE_W-1:0] ST_TIMEOUT = 8'hE2;
  localparam logic [BYTE_W-1:0] ST_BADOP   = 8'hE3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RX_OP   = 3'd1,
    S_RX_A    = 3'd2,
    S_RX_B    = 3'd3,
    S_RX_CHK  = 3'd4,
    S_EXEC    = 3'd5,
    S_TX_STAT = 3'd6,
    S_TX_WAIT = 3'd7
  } state_t;

  // Frame payload as assembled from the RX byte stream.
  typedef struct packed {
    logic [BYTE_W-1:0] opcode;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } frame_t;

  function automatic logic in_frame(input state_t s);
    return s inside {S_RX_OP, S_RX_A, S_RX_B, S_RX_CHK};
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Saturating inter-byte gap counter; expired once more than LIMIT ticks have elapsed.
module frame_timer
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TO_W  = TO_W_DEFAULT,
  parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic expired
);

  logic [TO_W-1:0] cnt;

  // Stops one past LIMIT so the count can never wrap back to a legal value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (clr) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (run && !expired) begin
      cnt <= cnt + TO_W'(1);
      if (cnt == TO_W'(LIMIT)) expired <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Framed UART command sequencer: assembles and validates a command frame,
// drives the ALU operands and returns a status byte plus the 4-byte result.
module uart_cmd_sequencer
  import uart_cmd_pkg::*;
#(
  parameter logic [BYTE_W-1:0] HEADER        = HEADER_DEFAULT,
  parameter int unsigned       TIMEOUT_TICKS = TIMEOUT_DEFAULT,
  parameter int unsigned       TO_W          = TO_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              baud_tick,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_done,
  input  logic              tx_done,
  input  logic [DATA_W-1:0] alu_result,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_start,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  output logic              busy,
  output logic              err_pulse
);

  state_t            state, state_d;
  frame_t            frame, frame_d;
  logic [1:0]        byte_cnt, byte_cnt_d;
  logic [BYTE_W-1:0] chk, chk_d;
  logic [BYTE_W-1:0] status, status_d;
  logic [DATA_W-1:0] result, result_d;
  logic [2:0]        tx_idx, tx_idx_d;
  logic [BYTE_W-1:0] tx_data_d;
  logic [DATA_W-1:0] alu_a_d, alu_b_d;
  logic [OP_W-1:0]   alu_opcode_d;
  logic              tx_start_d, busy_d, err_pulse_d;

  logic              rx_cur, rx_prev, tx_cur, tx_prev;
  logic              rx_evt_c, tx_evt_c, in_frame_c;
  logic              err_sel_c;
  logic [BYTE_W-1:0] err_code_c;
  logic              expired;

  // Registered done strobes; only rising edges count as events.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_cur  <= 1'b0;
      rx_prev <= 1'b0;
      tx_cur  <= 1'b0;
      tx_prev <= 1'b0;
    end else begin
      rx_cur  <= rx_done;
      rx_prev <= rx_cur;
      tx_cur  <= tx_done;
      tx_prev <= tx_cur;
    end
  end

  assign rx_evt_c   = rx_cur & ~rx_prev;
  assign tx_evt_c   = tx_cur & ~tx_prev;
  assign in_frame_c = in_frame(state);

  // A byte on the same cycle as a tick wins: clr has priority inside the timer.
  frame_timer #(
    .TO_W  (TO_W),
    .LIMIT (TIMEOUT_TICKS)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (rx_evt_c | ~in_frame_c),
    .run     (in_frame_c & baud_tick),
    .expired (expired)
  );

  always_comb begin
    state_d      = state;
    frame_d      = frame;
    byte_cnt_d   = byte_cnt;
    chk_d        = chk;
    status_d     = status;
    result_d     = result;
    tx_idx_d     = tx_idx;
    tx_data_d    = tx_data;
    alu_a_d      = alu_a;
    alu_b_d      = alu_b;
    alu_opcode_d = alu_opcode;
    tx_start_d   = 1'b0;
    err_pulse_d  = 1'b0;
    err_sel_c    = 1'b0;
    err_code_c   = ST_OK;

    case (state)
      S_IDLE: begin
        if (rx_evt_c && rx_data == HEADER) state_d = S_RX_OP;
      end
      S_RX_OP: begin
        if (rx_evt_c) begin
          frame_d.opcode = rx_data;
          chk_d          = rx_data;
          byte_cnt_d     = 2'd0;
          state_d        = S_RX_A;
        end
      end
      S_RX_A: begin
        if (rx_evt_c) begin
          frame_d.a  = {rx_data, frame.a[DATA_W-1:BYTE_W]};
          chk_d      = chk ^ rx_data;
          byte_cnt_d = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) state_d = S_RX_B;
        end
      end
      S_RX_B: begin
        if (rx_evt_c) begin
          frame_d.b  = {rx_data, frame.b[DATA_W-1:BYTE_W]};
          chk_d      = chk ^ rx_data;
          byte_cnt_d = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) state_d = S_RX_CHK;
        end
      end
      S_RX_CHK: begin
        // A checksum failure is reported even when the opcode is also bad.
        if (rx_evt_c) begin
          if (rx_data != chk) begin
            err_sel_c  = 1'b1;
            err_code_c = ST_BADCHK;
          end else if (frame.opcode[7:6] != 2'b00) begin
            err_sel_c  = 1'b1;
            err_code_c = ST_BADOP;
          end else begin
            alu_a_d      = frame.a;
            alu_b_d      = frame.b;
            alu_opcode_d = frame.opcode[OP_W-1:0];
            state_d      = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        result_d   = alu_result;
        status_d   = ST_OK;
        tx_data_d  = ST_OK;
        tx_idx_d   = 3'd0;
        tx_start_d = 1'b1;
        state_d    = S_TX_STAT;
      end
      S_TX_STAT: begin
        state_d = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        // Result bytes follow an OK status, least significant byte first.
        if (tx_evt_c) begin
          if (status != ST_OK || tx_idx == 3'd4) begin
            state_d = S_IDLE;
          end else begin
            tx_data_d  = result[BYTE_W-1:0];
            result_d   = {BYTE_W'(0), result[DATA_W-1:BYTE_W]};
            tx_idx_d   = tx_idx + 3'd1;
            tx_start_d = 1'b1;
            state_d    = S_TX_STAT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (in_frame_c && !rx_evt_c && expired) begin
      err_sel_c  = 1'b1;
      err_code_c = ST_TIMEOUT;
    end

    if (err_sel_c) begin
      status_d    = err_code_c;
      tx_data_d   = err_code_c;
      tx_idx_d    = 3'd0;
      tx_start_d  = 1'b1;
      err_pulse_d = 1'b1;
      state_d     = S_TX_STAT;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      frame      <= '0;
      byte_cnt   <= '0;
      chk        <= '0;
      status     <= '0;
      result     <= '0;
      tx_idx     <= '0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      busy       <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      state      <= state_d;
      frame      <= frame_d;
      byte_cnt   <= byte_cnt_d;
      chk        <= chk_d;
      status     <= status_d;
      result     <= result_d;
      tx_idx     <= tx_idx_d;
      tx_data    <= tx_data_d;
      tx_start   <= tx_start_d;
      alu_a      <= alu_a_d;
      alu_b      <= alu_b_d;
      alu_opcode <= alu_opcode_d;
      busy       <= busy_d;
      err_pulse  <= err_pulse_d;
    end
  end

endmodule
